// File: rtl/fir_mac_decim.sv
// Time-multiplexed FIR with integer decimation and one shared MAC.
// Define FIR_SAT_EN to saturate dout; otherwise dout wraps to OW bits.
module fir_mac_decim #(
  parameter int N_TAPS = 16,
  parameter int WIDTH  = 14,
  parameter int CW     = 16,
  parameter int OW     = 24,
  parameter int SHIFT  = 8,
  parameter int DECIM  = 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic signed [WIDTH-1:0]   din,
  input  logic                      din_valid,
  output logic                      busy,
  input  logic                      coeff_we,
  input  logic [$clog2(N_TAPS)-1:0] coeff_addr,
  input  logic signed [CW-1:0]      coeff_wdata,
  output logic signed [OW-1:0]      dout,
  output logic                      dout_valid,
  output logic                      overrun,
  input  logic                      clr
);

  localparam int AW  = $clog2(N_TAPS);
  localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW  = WIDTH + CW;
  localparam int ACW = PW + AW;
  localparam int SW  = ACW + 1;
  localparam logic signed [SW-1:0] ONE_S = 1;
  localparam logic signed [SW-1:0] RND =
    (SHIFT > 0) ? (ONE_S <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`ifdef FIR_SAT_EN
  localparam int EW = ((SW > OW) ? SW : OW) + 1;
  localparam logic signed [EW-1:0] ONE_E = 1;
  localparam logic signed [EW-1:0] SMAX = (ONE_E <<< (OW - 1)) - ONE_E;
  localparam logic signed [EW-1:0] SMIN = -(ONE_E <<< (OW - 1));
`endif

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] hist [N_TAPS];
  logic signed [CW-1:0]    coef [N_TAPS];
  logic [AW-1:0]           wptr;
  logic [AW-1:0]           rptr;
  logic [AW-1:0]           k;
  logic [DW-1:0]           dcnt;
  logic signed [ACW-1:0]   acc;

  logic                    accept;
  logic                    last;
  logic                    start;
  logic                    drop;
  logic signed [CW-1:0]    c_sel;
  logic signed [WIDTH-1:0] x_sel;
  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    rnd;
  logic signed [SW-1:0]    sh;
  logic signed [OW-1:0]    res;

  function automatic logic signed [CW-1:0] rst_coef(input int i);
    int v;
    v = 0;
    if (N_TAPS == 16) begin
      case (i)
        0, 15:   v = 311;
        1, 14:   v = 469;
        2, 13:   v = 917;
        3, 12:   v = 1582;
        4, 11:   v = 2352;
        5, 10:   v = 3091;
        6, 9:    v = 3671;
        7, 8:    v = 3990;
        default: v = 0;
      endcase
    end
    return CW'(v);
  endfunction

  assign accept = din_valid & ~busy;
  assign last   = (dcnt == DW'(DECIM - 1));
  assign start  = accept & last;
  assign drop   = busy & (din_valid | coeff_we);

  // rptr walks backwards from the newest sample, so tap k meets x[n-k]
  assign c_sel = coef[k];
  assign x_sel = hist[rptr];
  assign prod  = PW'(c_sel) * PW'(x_sel);

  assign rnd = SW'(acc) + RND;
  assign sh  = rnd >>> SHIFT;

`ifdef FIR_SAT_EN
  logic signed [EW-1:0] ext;
  assign ext = EW'(sh);
  always_comb begin
    res = OW'(ext);
    if (ext > SMAX)
      res = OW'(SMAX);
    else if (ext < SMIN)
      res = OW'(SMIN);
  end
`else
  always_comb begin
    res = OW'(sh);
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      k          <= '0;
      dcnt       <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= rst_coef(i);
      end
    end else begin
      dout_valid <= 1'b0;

      if (drop)
        overrun <= 1'b1;
      else if (clr)
        overrun <= 1'b0;

      if (coeff_we && !busy)
        coef[coeff_addr] <= coeff_wdata;

      if (accept) begin
        hist[wptr] <= din;
        wptr <= (wptr == AW'(N_TAPS - 1)) ? '0 : wptr + 1'b1;
        dcnt <= last ? '0 : dcnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            busy  <= 1'b1;
            rptr  <= wptr;
            k     <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc  <= acc + ACW'(prod);
          rptr <= (rptr == '0) ? AW'(N_TAPS - 1) : rptr - 1'b1;
          k    <= k + 1'b1;
          if (k == AW'(N_TAPS - 1))
            state <= OUT;
        end
        OUT: begin
          dout       <= res;
          dout_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_decim.sv
// Scoreboard bench for fir_mac_decim in two configurations.
// Unit 0: SHIFT=8 DECIM=1 OW=24; unit 1: SHIFT=0 DECIM=4 OW=16.
`timescale 1ns/1ps
module tb_fir_mac_decim;

  localparam int N = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic signed [13:0] din [2];
  logic               dv [2];
  logic               we [2];
  logic               clr [2];
  logic [3:0]         addr [2];
  logic signed [15:0] wd [2];

  logic               busy_a, busy_b;
  logic               dval_a, dval_b;
  logic               ovr_a, ovr_b;
  logic signed [23:0] dout_a;
  logic signed [15:0] dout_b;

  fir_mac_decim #(
    .N_TAPS(16), .WIDTH(14), .CW(16),
    .OW(24), .SHIFT(8), .DECIM(1)
  ) u_a (
    .clk(clk), .n_rst(n_rst),
    .din(din[0]), .din_valid(dv[0]),
    .busy(busy_a),
    .coeff_we(we[0]), .coeff_addr(addr[0]),
    .coeff_wdata(wd[0]),
    .dout(dout_a), .dout_valid(dval_a),
    .overrun(ovr_a), .clr(clr[0])
  );

  fir_mac_decim #(
    .N_TAPS(16), .WIDTH(14), .CW(16),
    .OW(16), .SHIFT(0), .DECIM(4)
  ) u_b (
    .clk(clk), .n_rst(n_rst),
    .din(din[1]), .din_valid(dv[1]),
    .busy(busy_b),
    .coeff_we(we[1]), .coeff_addr(addr[1]),
    .coeff_wdata(wd[1]),
    .dout(dout_b), .dout_valid(dval_b),
    .overrun(ovr_b), .clr(clr[1])
  );

  int checks = 0;
  int fails = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint v;
    int     e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int rc [N] = '{311, 469, 917, 1582, 2352, 3091, 3671, 3990,
                 3990, 3671, 3091, 2352, 1582, 917, 469, 311};
  int sh_u [2] = '{8, 0};
  int ow_u [2] = '{24, 16};
  int dec_u [2] = '{1, 4};

  int h [2][N];
  int c [2][N];
  int free_e [2];
  int dc [2];
  bit ov [2];

  longint last_a = 0;
  longint last_b = 0;

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < N; k++) begin
        h[u][k] = 0;
        c[u][k] = rc[k];
      end
      free_e[u] = 0;
      dc[u] = 0;
      ov[u] = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  function automatic longint post(longint acc, int s, int w);
    longint v;
    longint lim;
    v = acc;
    lim = longint'(1) <<< (w - 1);
    if (s > 0)
      v = v + (longint'(1) <<< (s - 1));
    v = v >>> s;
`ifdef FIR_SAT_EN
    if (v > lim - 1)
      v = lim - 1;
    else if (v < -lim)
      v = -lim;
`else
    v = v & ((lim <<< 1) - 1);
    if (v >= lim)
      v = v - (lim <<< 1);
`endif
    return v;
  endfunction

  task automatic push(int u, longint v, int e);
    exp_t t;
    t.v = v;
    t.e = e;
    if (u == 0)
      qa.push_back(t);
    else
      qb.push_back(t);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle sample strobe; the model decides acceptance from its own timing
  task automatic samp(int u, int x, bit with_clr = 1'b0);
    int e;
    longint acc;
    e = cyc + 1;
    acc = 0;
    if (with_clr)
      ov[u] = 1'b0;
    if (e >= free_e[u]) begin
      for (int k = N - 1; k > 0; k--)
        h[u][k] = h[u][k-1];
      h[u][0] = x;
      if (dc[u] == dec_u[u] - 1) begin
        dc[u] = 0;
        for (int k = 0; k < N; k++)
          acc += longint'(c[u][k]) * longint'(h[u][k]);
        push(u, post(acc, sh_u[u], ow_u[u]), e + N + 1);
        free_e[u] = e + N + 2;
      end else begin
        dc[u]++;
      end
    end else begin
      ov[u] = 1'b1;
    end
    din[u] = 14'(x);
    dv[u] = 1'b1;
    clr[u] = with_clr;
    @(negedge clk);
    dv[u] = 1'b0;
    clr[u] = 1'b0;
  endtask

  task automatic wr(int u, int k, int val);
    if (cyc + 1 >= free_e[u])
      c[u][k] = val;
    else
      ov[u] = 1'b1;
    addr[u] = 4'(k);
    wd[u] = 16'(val);
    we[u] = 1'b1;
    @(negedge clk);
    we[u] = 1'b0;
  endtask

  task automatic clear_ovr(int u);
    ov[u] = 1'b0;
    clr[u] = 1'b1;
    @(negedge clk);
    clr[u] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (!n_rst) begin
      last_a = 0;
      last_b = 0;
    end else begin
      if (dval_a) begin
        check("a_spur", longint'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          t = qa.pop_front();
          check("a_dout", dout_a, t.v);
          check("a_lat", cyc, t.e);
        end
        last_a = dout_a;
      end else begin
        check("a_hold", dout_a, last_a);
      end
      if (dval_b) begin
        check("b_spur", longint'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          t = qb.pop_front();
          check("b_dout", dout_b, t.v);
          check("b_lat", cyc, t.e);
        end
        last_b = dout_b;
      end else begin
        check("b_hold", dout_b, last_b);
      end
    end
  end

  initial begin
    int n;
    for (int u = 0; u < 2; u++) begin
      din[u] = '0;
      dv[u] = 1'b0;
      we[u] = 1'b0;
      clr[u] = 1'b0;
      addr[u] = '0;
      wd[u] = '0;
    end
    model_reset();
    n_rst = 1'b0;
    idle(3);
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_dval_a", dval_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_ovr_b", ovr_b, 0);
    n_rst = 1'b1;
    idle(2);

    // unit 0: impulse through reset taps, busy window length
    samp(0, 1);
    check("a_busy_on", busy_a, 1);
    n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("a_busy_len", n, 17);
    for (int i = 0; i < 16; i++) begin
      samp(0, 0);
      idle(17);
    end

    // DC full scale; reset taps sum to 32766
    for (int i = 0; i < 16; i++) begin
      samp(0, 8191);
      idle(17);
    end
    idle(2);
    check("a_dc", last_a, 1048384);

    for (int i = 0; i < 6; i++) begin
      samp(0, int'($urandom_range(16383)) - 8192);
      idle(17);
    end
    samp(0, -8192);
    idle(17);

    // a start one cycle too early is dropped; the exact spacing is accepted
    samp(0, 100);
    idle(16);
    samp(0, 200);
    check("a_ovr_early", ovr_a, ov[0]);
    samp(0, 300);
    check("a_ovr_sticky", ovr_a, ov[0]);
    idle(17);
    clear_ovr(0);
    check("a_ovr_clr", ovr_a, ov[0]);

    samp(0, 50);
    samp(0, 60);
    check("a_ovr_b2b", ovr_a, ov[0]);
    idle(16);
    samp(0, 70);
    samp(0, 80, 1'b1);
    check("a_ovr_clr_drop", ovr_a, ov[0]);
    idle(16);
    clear_ovr(0);
    check("a_ovr_clr2", ovr_a, ov[0]);

    samp(0, 1000);
    wr(0, 3, 999);
    check("a_ovr_we", ovr_a, ov[0]);
    idle(16);
    clear_ovr(0);

    wr(0, 0, -2000);
    samp(0, 1234);
    idle(17);
    wr(0, 15, 5000);
    samp(0, -3000);
    idle(17);
    samp(0, 4000);
    idle(17);

    // reset mid-MAC aborts, clears history and taps
    samp(0, 5000);
    idle(5);
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_dout", dout_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_dval", dval_a, 0);
    n_rst = 1'b1;
    idle(25);
    samp(0, 7);
    idle(18);
    check("a_post_rst", last_a, 9);

    // unit 1: decimated impulse, non-start samples back to back
    for (int i = 0; i < 20; i++) begin
      samp(1, (i == 0) ? 1 : 0);
      if (i % 4 == 3)
        idle(18);
      if (i == 3)
        check("b_imp3", last_b, 1582);
      if (i == 7)
        check("b_imp7", last_b, 3990);
    end

    for (int k = 0; k < N; k++)
      wr(1, k, 16383);
    for (int i = 0; i < 16; i++) begin
      samp(1, 8191);
      if (i % 4 == 3)
        idle(18);
    end
`ifdef FIR_SAT_EN
    check("b_sat_pos", last_b, 32767);
`else
    check("b_sat_pos", last_b, 16);
`endif
    for (int i = 0; i < 16; i++) begin
      samp(1, -8192);
      if (i % 4 == 3)
        idle(18);
    end
`ifdef FIR_SAT_EN
    check("b_sat_neg", last_b, -32768);
`else
    check("b_sat_neg", last_b, 0);
`endif
    check("b_ovr", ovr_b, ov[1]);

    n = 0;
    while ((qa.size() + qb.size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", qa.size() + qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
